// File: rtl/rv_pkg.sv
// Shared RV decode definitions: base opcodes and the immediate-format classifier
// used by the ID stage.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                                      fmt = FMT_S;
      OP_BRANCH:                                     fmt = FMT_B;
      OP_LUI, OP_AUIPC:                              fmt = FMT_U;
      OP_JAL:                                        fmt = FMT_J;
      default:                                       fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// NREG x XLEN integer register file: one write port, three combinational read
// ports with write-through bypass; x0 and out-of-range indices read as zero.
module regfile_bypass #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      ra3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] rd3
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_r [NREG];

  function automatic logic in_range(input logic [4:0] a);
    return ({27'd0, a} < 32'(NREG));
  endfunction

  // Same-cycle write-back wins over the stored value so decode never sees stale data.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = {XLEN{1'b0}};
    if (a == 5'd0 || !in_range(a)) begin
      v = {XLEN{1'b0}};
    end else if (wb_en && wb_rd == a) begin
      v = wb_data;
    end else begin
      v = regs_r[a[AW-1:0]];
    end
    return v;
  endfunction

  // Register storage: synchronous clear, writes to x0 or beyond NREG dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_en && wb_rd != 5'd0 && in_range(wb_rd)) begin
      regs_r[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // Bypassed read ports.
  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
    rd3 = read_port(ra3);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV instruction-decode stage: register read, immediate generation, load-use
// bubble insertion and a valid/ready ID/EX pipeline register.
module id_stage_pipe
  import rv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      ctl_rs1_addr,
  output logic [XLEN-1:0] ctl_rs1_data,
  output logic            id_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc
);

  logic [6:0]        op_s;
  logic [4:0]        rs1_s;
  logic [4:0]        rs2_s;
  logic [XLEN-1:0]   rdata1_s;
  logic [XLEN-1:0]   rdata2_s;
  logic signed [31:0] imm32_s;
  logic [XLEN-1:0]   imm_s;
  logic              rs1_used_s;
  logic              rs2_used_s;
  logic              hazard_s;
  logic              adv_s;

  logic              id_valid_r;
  logic [31:0]       inst_r;
  logic [XLEN-1:0]   data1_r;
  logic [XLEN-1:0]   data2_r;
  logic [XLEN-1:0]   imm_r;
  logic [XLEN-1:0]   pc_r;

  assign op_s  = if_inst[6:0];
  assign rs1_s = if_inst[19:15];
  assign rs2_s = if_inst[24:20];

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .ra1     (rs1_s),
    .ra2     (rs2_s),
    .ra3     (ctl_rs1_addr),
    .rd1     (rdata1_s),
    .rd2     (rdata2_s),
    .rd3     (ctl_rs1_data)
  );

  // Immediate built as 32 bits, then sign-extended from inst[31] to XLEN.
  always_comb begin
    imm32_s = 32'sd0;
    case (imm_fmt_of(op_s))
      FMT_I:   imm32_s = {{20{if_inst[31]}}, if_inst[31:20]};
      FMT_S:   imm32_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      FMT_B:   imm32_s = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                          if_inst[30:25], if_inst[11:8], 1'b0};
      FMT_U:   imm32_s = {if_inst[31:12], 12'd0};
      FMT_J:   imm32_s = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                          if_inst[20], if_inst[30:21], 1'b0};
      default: imm32_s = 32'sd0;
    endcase
    imm_s = XLEN'(imm32_s);
  end

  // Load-use detection against the instruction currently in ID/EX.
  always_comb begin
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    hazard_s   = 1'b0;
    if (op_s == OP_LUI || op_s == OP_AUIPC || op_s == OP_JAL) begin
      rs1_used_s = 1'b0;
    end else begin
      rs1_used_s = 1'b1;
    end
    if (op_s == OP_OP || op_s == OP_OP32 || op_s == OP_STORE || op_s == OP_BRANCH) begin
      rs2_used_s = 1'b1;
    end else begin
      rs2_used_s = 1'b0;
    end
    if (id_valid_r && inst_r[6:0] == OP_LOAD && inst_r[11:7] != 5'd0 && if_valid) begin
      hazard_s = (rs1_used_s && rs1_s == inst_r[11:7]) ||
                 (rs2_used_s && rs2_s == inst_r[11:7]);
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign adv_s    = !id_valid_r || ex_ready;
  assign id_ready = flush || (adv_s && !hazard_s);

  // ID/EX register; bubbles only clear valid, payload is left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r <= 1'b0;
      inst_r     <= 32'd0;
      data1_r    <= {XLEN{1'b0}};
      data2_r    <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      pc_r       <= {XLEN{1'b0}};
    end else if (flush) begin
      id_valid_r <= 1'b0;
    end else if (adv_s && hazard_s) begin
      id_valid_r <= 1'b0;
    end else if (adv_s && if_valid) begin
      id_valid_r <= 1'b1;
      inst_r     <= if_inst;
      data1_r    <= rdata1_s;
      data2_r    <= rdata2_s;
      imm_r      <= imm_s;
      pc_r       <= if_pc;
    end else if (adv_s) begin
      id_valid_r <= 1'b0;
    end
  end

  assign id_valid = id_valid_r;
  assign opcode   = inst_r[6:0];
  assign rd       = inst_r[11:7];
  assign func3    = inst_r[14:12];
  assign rs1_addr = inst_r[19:15];
  assign rs2_addr = inst_r[24:20];
  assign func7    = inst_r[31:25];
  assign data1    = data1_r;
  assign data2    = data2_r;
  assign imm_ext  = imm_r;
  assign pc       = pc_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: vector table through a scoreboard queue,
// plus hand-written load-use, stall/flush, reset and XLEN=32/NREG=16 sequences.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // XLEN=64, NREG=32 instance
  logic        rst, flush, if_valid, ex_ready, wb_en, id_ready, id_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc, wb_data, ctl_rs1_data, data1, data2, imm_ext, pc;
  logic [4:0]  wb_rd, ctl_rs1_addr, rd, rs1_addr, rs2_addr;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;

  // XLEN=32, NREG=16 instance
  logic        s_rst, s_flush, s_if_valid, s_ex_ready, s_wb_en, s_id_ready, s_id_valid;
  logic [31:0] s_if_inst, s_if_pc, s_wb_data, s_ctl_rs1_data, s_data1, s_data2, s_imm_ext, s_pc;
  logic [4:0]  s_wb_rd, s_ctl_rs1_addr, s_rd, s_rs1_addr, s_rs2_addr;
  logic [6:0]  s_opcode, s_func7;
  logic [2:0]  s_func3;

  id_stage_pipe #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready), .ex_ready(ex_ready), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .ctl_rs1_addr(ctl_rs1_addr),
    .ctl_rs1_data(ctl_rs1_data), .id_valid(id_valid), .opcode(opcode),
    .func3(func3), .func7(func7), .rd(rd), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .data1(data1), .data2(data2), .imm_ext(imm_ext), .pc(pc)
  );

  id_stage_pipe #(.XLEN(32), .NREG(16)) dut32 (
    .clk(clk), .rst(s_rst), .flush(s_flush), .if_valid(s_if_valid), .if_inst(s_if_inst),
    .if_pc(s_if_pc), .id_ready(s_id_ready), .ex_ready(s_ex_ready), .wb_en(s_wb_en),
    .wb_rd(s_wb_rd), .wb_data(s_wb_data), .ctl_rs1_addr(s_ctl_rs1_addr),
    .ctl_rs1_data(s_ctl_rs1_data), .id_valid(s_id_valid), .opcode(s_opcode),
    .func3(s_func3), .func7(s_func7), .rd(s_rd), .rs1_addr(s_rs1_addr),
    .rs2_addr(s_rs2_addr), .data1(s_data1), .data2(s_data2), .imm_ext(s_imm_ext), .pc(s_pc)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
  } rec_t;

  rec_t q[$];
  rec_t last_exp;
  rec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input rec_t e);
    chk({tag, "_fields"}, {32'd0, func7, rs2_addr, rs1_addr, func3, rd, opcode}, {32'd0, e.inst});
    chk({tag, "_data1"}, data1, e.d1);
    chk({tag, "_data2"}, data2, e.d2);
    chk({tag, "_imm"}, imm_ext, e.imm);
    chk({tag, "_pc"}, pc, e.pc);
  endtask

  // One clock; pops the scoreboard when a new instruction lands in ID/EX.
  task automatic cycle();
    logic adv_b;
    adv_b = !id_valid || ex_ready;
    @(posedge clk);
    @(negedge clk);
    if (id_valid && adv_b) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got inst %h expected none",
                 {func7, rs2_addr, rs1_addr, func3, rd, opcode});
      end else begin
        last_exp = q.pop_front();
        chk_fields("sb", last_exp);
      end
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] p);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = p;
  endtask

  task automatic expect_out(input logic [31:0] inst, input logic [63:0] p,
                            input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm);
    rec_t r;
    r.inst = inst; r.pc = p; r.d1 = d1; r.d2 = d2; r.imm = imm;
    q.push_back(r);
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    cycle();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = 32'd0; if_pc = 64'd0;
    ex_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0; ctl_rs1_addr = 5'd0;
    s_rst = 1'b1; s_flush = 1'b0; s_if_valid = 1'b0; s_if_inst = 32'd0; s_if_pc = 32'd0;
    s_ex_ready = 1'b1; s_wb_en = 1'b0; s_wb_rd = 5'd0; s_wb_data = 32'd0; s_ctl_rs1_addr = 5'd0;
    last_exp = '{32'd0, 64'd0, 64'd0, 64'd0, 64'd0};

    vecs[0] = '{32'h002082B3, 64'h1000, 64'd7, 64'd3, 64'd0};                       // add x5,x1,x2
    vecs[1] = '{32'hFFF08293, 64'h1004, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};     // addi x5,x1,-1
    vecs[2] = '{32'hFE2080E3, 64'h1008, 64'd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFE0};     // beq -32
    vecs[3] = '{32'h000202B7, 64'h100C, 64'd0, 64'd0, 64'h0000_0000_0002_0000};     // lui x5,0x20
    vecs[4] = '{32'hFEDFF0EF, 64'h1010, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFEC};     // jal x1,-20
    vecs[5] = '{32'h0020A423, 64'h1014, 64'd7, 64'd3, 64'd8};                       // sw x2,8(x1)
    vecs[6] = '{32'h0051829B, 64'h1018, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd5};     // addiw x5,x3,5
    vecs[7] = '{32'hFFFFF317, 64'h101C, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_F000};     // auipc x6,0xFFFFF
    vecs[8] = '{32'hFFFFFFFF, 64'h1020, 64'd0, 64'd0, 64'd0};                       // unknown opcode
    vecs[9] = '{32'h80009073, 64'h1024, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_F800};     // csrrw, imm sign

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;
    #1;
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_fields", {32'd0, func7, rs2_addr, rs1_addr, func3, rd, opcode}, 64'd0);
    chk("rst_data1", data1, 64'd0);
    chk("rst_imm", imm_ext, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_id_ready", {63'd0, id_ready}, 64'd1);

    wb(5'd1, 64'd7);
    wb(5'd2, 64'd3);
    wb(5'd3, 64'hFFFF_FFFF_FFFF_FFF0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].inst, vecs[i].pc);
      expect_out(vecs[i].inst, vecs[i].pc, vecs[i].d1, vecs[i].d2, vecs[i].imm);
      cycle();
    end
    if_valid = 1'b0;
    cycle();
    chk("table_drained", 64'(q.size()), 64'd0);

    // Write-through bypass and x0
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd5; ctl_rs1_addr = 5'd1;
    drive(32'h000082B3, 64'h1100);
    #1 chk("ctl_bypass", ctl_rs1_data, 64'd5);
    expect_out(32'h000082B3, 64'h1100, 64'd5, 64'd0, 64'd0);
    cycle();
    wb_rd = 5'd0; wb_data = 64'd9; ctl_rs1_addr = 5'd0;
    drive(32'h000002B3, 64'h1104);
    #1 chk("ctl_x0", ctl_rs1_data, 64'd0);
    expect_out(32'h000002B3, 64'h1104, 64'd0, 64'd0, 64'd0);
    cycle();
    wb_en = 1'b0; if_valid = 1'b0; ctl_rs1_addr = 5'd1;
    #1 chk("ctl_x1_stored", ctl_rs1_data, 64'd5);

    // Load-use: ld x6,0(x1) then add x7,x6,x2
    drive(32'h0000B303, 64'h1200);
    expect_out(32'h0000B303, 64'h1200, 64'd5, 64'd0, 64'd0);
    cycle();
    drive(32'h002303B3, 64'h1204);
    #1 chk("lu_stall_ready", {63'd0, id_ready}, 64'd0);
    cycle();
    chk("lu_bubble_valid", {63'd0, id_valid}, 64'd0);
    chk("lu_ready_after", {63'd0, id_ready}, 64'd1);
    expect_out(32'h002303B3, 64'h1204, 64'd0, 64'd3, 64'd0);
    cycle();
    // Same with independent add x7,x1,x2
    drive(32'h0000B303, 64'h1300);
    expect_out(32'h0000B303, 64'h1300, 64'd5, 64'd0, 64'd0);
    cycle();
    drive(32'h002083B3, 64'h1304);
    #1 chk("nolu_ready", {63'd0, id_ready}, 64'd1);
    expect_out(32'h002083B3, 64'h1304, 64'd5, 64'd3, 64'd0);
    cycle();
    if_valid = 1'b0;
    cycle();
    chk("lu_drained", 64'(q.size()), 64'd0);

    // Back-pressure then flush
    drive(32'h002082B3, 64'h2000);
    expect_out(32'h002082B3, 64'h2000, 64'd5, 64'd3, 64'd0);
    cycle();
    ex_ready = 1'b0;
    drive(32'hFFF08293, 64'h2004);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", {63'd0, id_ready}, 64'd0);
      cycle();
      chk("stall_valid", {63'd0, id_valid}, 64'd1);
      chk_fields("stall", last_exp);
    end
    flush = 1'b1;
    #1 chk("flush_ready", {63'd0, id_ready}, 64'd1);
    cycle();
    chk("flush_valid", {63'd0, id_valid}, 64'd0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) cycle();
    chk("flush_gone", {63'd0, id_valid}, 64'd0);
    chk("flush_drained", 64'(q.size()), 64'd0);

    // Reset in the middle of a stall
    drive(32'h002082B3, 64'h3000);
    expect_out(32'h002082B3, 64'h3000, 64'd5, 64'd3, 64'd0);
    cycle();
    ex_ready = 1'b0; if_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; ex_ready = 1'b1; ctl_rs1_addr = 5'd1;
    #1;
    chk("mrst_valid", {63'd0, id_valid}, 64'd0);
    chk("mrst_fields", {32'd0, func7, rs2_addr, rs1_addr, func3, rd, opcode}, 64'd0);
    chk("mrst_data1", data1, 64'd0);
    chk("mrst_data2", data2, 64'd0);
    chk("mrst_imm", imm_ext, 64'd0);
    chk("mrst_pc", pc, 64'd0);
    chk("mrst_regfile", ctl_rs1_data, 64'd0);

    // XLEN=32, NREG=16 instance
    @(negedge clk);
    s_wb_en = 1'b1; s_wb_rd = 5'd1; s_wb_data = 32'd7;
    @(negedge clk);
    s_wb_rd = 5'd20; s_wb_data = 32'hDEADBEEF;
    @(negedge clk);
    s_wb_en = 1'b0; s_ctl_rs1_addr = 5'd20;
    #1 chk("n16_x20_ignored", {32'd0, s_ctl_rs1_data}, 64'd0);
    s_ctl_rs1_addr = 5'd1;
    #1 chk("n16_x1", {32'd0, s_ctl_rs1_data}, 64'd7);
    s_if_valid = 1'b1; s_if_inst = 32'hFFF08293; s_if_pc = 32'h400;
    @(negedge clk);
    chk("x32_valid", {63'd0, s_id_valid}, 64'd1);
    chk("x32_imm", {32'd0, s_imm_ext}, 64'h0000_0000_FFFF_FFFF);
    chk("x32_data1", {32'd0, s_data1}, 64'd7);
    s_if_inst = 32'h001A02B3; s_if_pc = 32'h404;
    @(negedge clk);
    chk("x32_rs20_zero", {32'd0, s_data1}, 64'd0);
    chk("x32_rs2", {32'd0, s_data2}, 64'd7);
    chk("x32_pc", {32'd0, s_pc}, 64'h404);
    s_if_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised RV instruction-decode stage: integer register file, full immediate generator and a registered ID/EX pipeline register with valid/ready handshake.
- Adds internal load-use hazard detection with bubble insertion, synchronous flush, write-through bypass and an extra combinational control read port for branch/jalr resolution.
- Sits between the IF stage (upstream) and the EX stage (downstream) of the CPU pipeline.

Parameters:
XLEN, 64, data/register width; legal values 32 or 64.
NREG, 32, number of architectural registers (32 = RV-I, 16 = RV-E); addresses >= NREG read 0 and ignore writes.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  kill instruction being accepted and contents of the ID/EX register
if_valid  in  1  if_inst/if_pc valid
if_inst  in  32  instruction word
if_pc  in  XLEN  PC of if_inst
id_ready  out  1  stage accepts if_inst this cycle (combinational)
ex_ready  in  1  EX consumes the ID/EX register this cycle
wb_en  in  1  write-back enable
wb_rd  in  5  write-back register index
wb_data  in  XLEN  write-back data
ctl_rs1_addr  in  5  control read-port address
ctl_rs1_data  out  XLEN  control read-port data (combinational, bypassed)
id_valid  out  1  ID/EX register holds a valid instruction
opcode  out  7  inst[6:0]
func3  out  3  inst[14:12]
func7  out  7  inst[31:25]
rd  out  5  inst[11:7]
rs1_addr, rs2_addr  out  5 each  inst[19:15], inst[24:20]
data1, data2  out  XLEN each  operand values
imm_ext  out  XLEN  sign-extended immediate
pc  out  XLEN  registered if_pc

Behaviour:
- Reset: all ID/EX outputs 0, id_valid=0, all registers 0; takes effect on the clock edge with rst=1 and overrides all other inputs.
- Register file:
  - Write on posedge when wb_en && wb_rd!=0 && wb_rd<NREG.
  - x0 always reads 0.
  - Reads are combinational with write-through bypass: if wb_en && wb_rd==addr && addr!=0, return wb_data. Same rule applies to ctl_rs1_data.
- Immediate generation by opcode:
  - I (0000011, 0010011, 0011011, 1100111, 1110011)
  - S (0100011)
  - B (1100011; bit0=0)
  - U (0110111, 0010111; low 12 bits 0)
  - J (1101111; bit0=0)
  - Any other opcode: 0.
  - Sign bit is inst[31], extended to XLEN.
- Operand use:
  - rs1 is used unless opcode is LUI, AUIPC or JAL.
  - rs2 is used for opcodes 0110011, 0111011, 0100011, 1100011.
- Hazard is asserted when all of the following hold:
  - id_valid=1 and opcode==0000011 (a load sits in ID/EX)
  - rd!=0
  - if_valid=1
  - rd matches a used rs1/rs2 of if_inst
- Handshake:
  - adv = !id_valid || ex_ready.
  - id_ready = flush || (adv && !hazard).
- ID/EX update, in priority order:
  1. rst: clear.
  2. flush: id_valid<=0; if_inst is dropped.
  3. adv && hazard: bubble, id_valid<=0, with other fields don't-care.
  4. adv && if_valid: load all fields, id_valid<=1.
  5. adv && !if_valid: id_valid<=0.
  6. !adv: hold all fields; EX is stalled.
- Latency: 1 cycle from acceptance to id_valid.
- Load-use costs exactly one bubble. Forwarding from later stages is outside this block.
- Simultaneous write-back and decode of the same register: decode sees wb_data through the bypass.
- When XLEN=32, 0011011/0111011 decode normally; EX is responsible for rejecting them.

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_LOAD, OP_IMM, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OP32, OP_SYSTEM) and an imm_fmt enum (I, S, B, U, J, NONE).
- One sub-module: regfile_bypass (NREG x XLEN, 1 write port, 3 bypassed read ports, synchronous reset).
- Immediate generation and hazard detection stay inline.

Test Plan:
1. Reset then decode: wb writes x1=7, x2=3; if_inst=0x002082B3 (add x5,x1,x2), ex_ready=1 -> next cycle id_valid=1, opcode=0110011, rd=5, data1=7, data2=3, imm_ext=0.
2. Immediates: addi x5,x1,-1 (0xFFF08293) -> imm_ext all ones. beq x1,x2,-32 (0xFE2080E3) -> imm_ext=-32. lui x5,0x20 (0x000202B7) -> imm_ext=0x20000. jal x1,-20 (0xFEDFF0EF) -> imm_ext=-20.
3. Bypass/x0: wb_en=1, wb_rd=1, wb_data=5 in the same cycle add x5,x1,x0 is accepted -> data1=5, data2=0. wb_rd=0, wb_data=9 -> x0 still reads 0. ctl_rs1_addr=1 in that cycle -> ctl_rs1_data=5.
4. Load-use: accept ld x6,0(x1), then present add x7,x6,x2 -> id_ready=0 for one cycle, id_valid=0 (bubble), add accepted next cycle. The same sequence with add x7,x1,x2 -> no stall.
5. Back-pressure and flush: hold ex_ready=0 for 3 cycles -> ID/EX fields stable, id_ready=0. Assert flush with if_valid=1 -> next cycle id_valid=0 and the flushed instruction never appears.
6. Parameter sweep: XLEN=32, NREG=16 -> write x20 ignored and reads 0; addi x5,x1,-1 gives imm_ext=0xFFFFFFFF. Assert rst mid-stall -> all outputs 0 on the next cycle.
